// File: rtl/cpu_types.sv
// Shared core types: fetch tag and fetch entry payloads carried through the IFU FIFOs.
package cpu_types;

  localparam int unsigned CT_NTHREADS = 4;
  localparam int unsigned CT_XLEN     = 32;
  localparam int unsigned CT_TID_W    = $clog2(CT_NTHREADS);

  typedef struct packed {
    logic [CT_TID_W-1:0] tid;
    logic [CT_XLEN-1:0]  pc;
    logic                epoch;
  } fetch_tag_t;

  typedef struct packed {
    fetch_tag_t         tag;
    logic [CT_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with registered storage; head word is visible on rdata_o while not empty.
module ifu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ifu_mt.sv
// Multithreaded fetch unit: round-robin thread pick, credit-limited in-order fetches,
// per-thread epochs so redirected threads drop stale instructions at the output.
module ifu_mt
  import cpu_types::*;
#(
  parameter int unsigned      NTHREADS     = CT_NTHREADS,
  parameter int unsigned      XLEN         = CT_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h0000_0200),
  parameter int unsigned      DEPTH        = 4,
  localparam int unsigned     TID_W        = $clog2(NTHREADS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NTHREADS-1:0] thread_en,
  input  logic                redirect_valid,
  input  logic [TID_W-1:0]    redirect_tid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [XLEN-1:0]     imem_rsp_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [XLEN-1:0]     if_instr,
  output logic [XLEN-1:0]     if_pc,
  output logic [TID_W-1:0]    if_tid
);

  localparam int unsigned TAG_W = $bits(fetch_tag_t);
  localparam int unsigned ENT_W = $bits(fetch_entry_t);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]     pc_q [NTHREADS];
  logic [XLEN-1:0]     pc_d [NTHREADS];
  logic [NTHREADS-1:0] epoch_q, epoch_d;
  logic [TID_W-1:0]    rr_q, rr_d;
  logic                slot_valid_q, slot_valid_d;
  fetch_tag_t          slot_q, slot_d;

  logic [TAG_W-1:0] tag_rdata;
  logic [ENT_W-1:0] data_wdata, data_rdata;
  logic             tag_full, tag_empty, data_full, data_empty, data_pop;
  logic [CNT_W-1:0] tag_cnt, data_cnt;
  logic [CNT_W:0]   used_c;
  logic             credit_ok, req_hs, slot_free, load, pick_found, head_stale;
  logic [TID_W-1:0] pick_tid;
  fetch_entry_t     head;
  int               idx;

  // Slot in flight, tags awaiting response and buffered entries all hold a credit
  assign used_c    = (CNT_W+1)'(tag_cnt) + (CNT_W+1)'(data_cnt) + (CNT_W+1)'(slot_valid_q);
  assign credit_ok = used_c < (CNT_W+1)'(DEPTH);
  assign req_hs    = slot_valid_q & imem_req_ready;
  assign slot_free = ~slot_valid_q | req_hs;
  assign load      = slot_free & pick_found & credit_ok;

  // First enabled thread at or after rr_q; descending scan so the nearest one wins
  always_comb begin
    pick_found = 1'b0;
    pick_tid   = '0;
    idx        = 0;
    for (int i = int'(NTHREADS) - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= int'(NTHREADS)) idx = idx - int'(NTHREADS);
      if (thread_en[TID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_tid   = TID_W'(idx);
      end
    end
  end

  always_comb begin
    pc_d         = pc_q;
    epoch_d      = epoch_q;
    rr_d         = rr_q;
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    if (slot_free) begin
      slot_valid_d = load;
      if (load) begin
        slot_d.tid      = pick_tid;
        slot_d.pc       = pc_q[pick_tid];
        slot_d.epoch    = epoch_q[pick_tid];
        pc_d[pick_tid]  = pc_q[pick_tid] + XLEN'(4);
        rr_d            = (pick_tid == TID_W'(NTHREADS - 1)) ? '0 : pick_tid + TID_W'(1);
      end
    end
    // Applied last so it overrides a same-cycle increment of the redirected thread
    if (redirect_valid) begin
      pc_d[redirect_tid]    = {redirect_pc[XLEN-1:2], 2'b00};
      epoch_d[redirect_tid] = ~epoch_q[redirect_tid];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NTHREADS); i++) pc_q[i] <= RESET_VECTOR;
      epoch_q      <= '0;
      rr_q         <= '0;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      rr_q         <= rr_d;
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
    end
  end

  ifu_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_hs),
    .wdata_i (slot_q),
    .pop_i   (imem_rsp_valid),
    .rdata_o (tag_rdata),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  assign data_wdata = {tag_rdata, imem_rsp_data};

  ifu_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (imem_rsp_valid),
    .wdata_i (data_wdata),
    .pop_i   (data_pop),
    .rdata_o (data_rdata),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_cnt)
  );

  // Head entries from an older epoch of their thread are drained without reaching decode
  assign head       = data_rdata;
  assign head_stale = ~data_empty & (head.tag.epoch != epoch_q[head.tag.tid]);
  assign if_valid   = ~data_empty & ~head_stale;
  assign data_pop   = head_stale | (if_valid & if_ready);
  assign if_instr   = head.instr;
  assign if_pc      = head.tag.pc;
  assign if_tid     = head.tag.tid;

  assign imem_req_valid = slot_valid_q;
  assign imem_req_addr  = slot_q.pc;

  rsp_without_tag_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> !tag_empty);
  tag_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    req_hs |-> (!tag_full || imem_rsp_valid));
  data_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (!data_full || data_pop));

endmodule

// File: tb/tb_ifu_mt.sv
// Bench for ifu_mt: in-order memory model, request/output scoreboards, vector table and corner sequences.
module tb_ifu_mt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  thread_en = 4'b0000;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_tid = 2'd0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  if_tid;

  ifu_mt #(.NTHREADS(4), .XLEN(32), .RESET_VECTOR(32'h0000_0200), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .thread_en      (thread_en),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_tid         (if_tid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] seq;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_req = 0;
  bit          mem_hold = 1'b0;
  logic [31:0] mem_pend[$];
  logic [31:0] exp_req[$];
  logic [65:0] exp_out[$];
  vec_t        vecs[5];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [65:0] ent(input logic [1:0] tid, input logic [31:0] pc);
    return {tid, pc, instr_of(pc)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut(input logic [3:0] en);
    rst_n          = 1'b0;
    thread_en      = en;
    redirect_valid = 1'b0;
    redirect_tid   = 2'd0;
    redirect_pc    = 32'd0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    mem_hold       = 1'b0;
    step(2);
    exp_req.delete();
    exp_out.delete();
    n_req = 0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_req.size() + exp_out.size()) > 0 && k < 200) begin
      step(1);
      k++;
    end
    check(name, 128'(exp_req.size() + exp_out.size()), 128'(0));
  endtask

  // In-order memory: a request accepted in one cycle responds in the next unless held
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_pend.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (!mem_hold && mem_pend.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) mem_pend.push_back(imem_req_addr);
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      n_req++;
      if (exp_req.size() > 0) check("req_addr", 128'(imem_req_addr), 128'(exp_req.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      if (exp_out.size() > 0) check("out_tid_pc_instr", 128'({if_tid, if_pc, if_instr}),
                                    128'(exp_out.pop_front()));
    end
  end

  initial begin
    vecs[0] = '{4'b1111, 16'hE4E4};
    vecs[1] = '{4'b0101, 16'h8888};
    vecs[2] = '{4'b1000, 16'hFFFF};
    vecs[3] = '{4'b0110, 16'h9999};
    vecs[4] = '{4'b1011, 16'h4D34};

    // Reset values and first request timing
    reset_dut(4'b1111);
    check("rst_req_valid", 128'(imem_req_valid), 128'(0));
    check("rst_req_addr", 128'(imem_req_addr), 128'(0));
    check("rst_if_valid", 128'(if_valid), 128'(0));
    check("rst_if_instr", 128'(if_instr), 128'(0));
    check("rst_if_pc", 128'(if_pc), 128'(0));
    check("rst_if_tid", 128'(if_tid), 128'(0));
    rst_n = 1'b1;
    check("pre_first_req_valid", 128'(imem_req_valid), 128'(0));
    step(1);
    check("first_req_valid", 128'(imem_req_valid), 128'(1));
    check("first_req_addr", 128'(imem_req_addr), 128'(32'h200));
    step(2);

    // Round-robin over enable masks; expected PCs from a per-thread grant count
    for (int v = 0; v < 5; v++) begin
      int cnt[4];
      reset_dut(vecs[v].en);
      for (int t = 0; t < 4; t++) cnt[t] = 0;
      for (int k = 0; k < 8; k++) begin
        logic [1:0]  tid;
        logic [31:0] pc;
        tid = vecs[v].seq[2*k +: 2];
        pc  = 32'h200 + 32'(4 * cnt[tid]);
        cnt[tid]++;
        exp_req.push_back(pc);
        exp_out.push_back(ent(tid, pc));
      end
      rst_n = 1'b1;
      wait_drain("rr_drain");
    end

    // Credit limit with decode stalled, then one pop frees exactly one request
    reset_dut(4'b1111);
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    exp_out.push_back(ent(2'd0, 32'h200));
    rst_n = 1'b1;
    step(20);
    check("credit_reqs", 128'(n_req), 128'(4));
    check("credit_req_valid", 128'(imem_req_valid), 128'(0));
    if_ready = 1'b1;
    step(1);
    if_ready = 1'b0;
    step(10);
    check("credit_refill", 128'(n_req), 128'(5));
    check("credit_left", 128'(exp_req.size() + exp_out.size()), 128'(0));

    // Memory stalls requests: slot held, other threads do not advance
    reset_dut(4'b1111);
    imem_req_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_req.push_back(32'h200);
      exp_out.push_back(ent(2'(t), 32'h200));
    end
    exp_req.push_back(32'h204);
    exp_out.push_back(ent(2'd0, 32'h204));
    rst_n = 1'b1;
    step(1);
    for (int c = 0; c < 3; c++) begin
      check("hold_valid", 128'(imem_req_valid), 128'(1));
      check("hold_addr", 128'(imem_req_addr), 128'(32'h200));
      step(1);
    end
    imem_req_ready = 1'b1;
    wait_drain("hold_drain");

    // Redirect tid1 with two fetches in flight and one buffered
    reset_dut(4'b0010);
    if_ready = 1'b0;
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    exp_req.push_back(32'h208);
    rst_n = 1'b1;
    step(3);
    thread_en = 4'b0000;
    mem_hold  = 1'b1;
    step(2);
    check("redir1_head_valid", 128'(if_valid), 128'(1));
    check("redir1_head_pc", 128'(if_pc), 128'(32'h200));
    check("redir1_reqs", 128'(n_req), 128'(3));
    redirect_valid = 1'b1;
    redirect_tid   = 2'd1;
    redirect_pc    = 32'h1000;
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h204);
    exp_req.push_back(32'h1004);
    exp_out.push_back(ent(2'd0, 32'h200));
    exp_out.push_back(ent(2'd1, 32'h1000));
    exp_out.push_back(ent(2'd0, 32'h204));
    exp_out.push_back(ent(2'd1, 32'h1004));
    step(1);
    check("redir1_stale_hidden", 128'(if_valid), 128'(0));
    redirect_valid = 1'b0;
    thread_en      = 4'b0011;
    mem_hold       = 1'b0;
    if_ready       = 1'b1;
    wait_drain("redir1_drain");

    // Redirect tid0 to a misaligned target in the cycle its slot loads
    reset_dut(4'b0001);
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
    exp_req.push_back(32'h208);
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h1004);
    exp_out.push_back(ent(2'd0, 32'h1000));
    exp_out.push_back(ent(2'd0, 32'h1004));
    rst_n = 1'b1;
    step(2);
    redirect_valid = 1'b1;
    redirect_tid   = 2'd0;
    redirect_pc    = 32'h1002;
    step(1);
    redirect_valid = 1'b0;
    check("redir0_loaded_addr", 128'(imem_req_addr), 128'(32'h208));
    wait_drain("redir0_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
